// File: rtl/mac_vec_if.sv
// Control, BRAM write and status bundle for the vector MAC engine.
// The master drives the run configuration and the memory writes. The slave reports the results.
interface mac_vec_if #(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int MO_WIDTH   = 32
) ();
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                    ctrl_start;
    logic [ADDR_WIDTH:0]     ctrl_num;
    logic [7:0]              ctrl_Za;
    logic [7:0]              ctrl_Zw;
    logic [7:0]              ctrl_Zo;
    logic [MO_WIDTH-1:0]     ctrl_M0;
    logic [5:0]              ctrl_n;
    logic [32*LANES-1:0]     ctrl_bias;
    logic                    ctrl_relu;
    logic                    act_we;
    logic [ADDR_WIDTH-1:0]   act_waddr;
    logic [7:0]              act_wdata;
    logic                    wgt_we;
    logic [LW-1:0]           wgt_lane;
    logic [ADDR_WIDTH-1:0]   wgt_waddr;
    logic [7:0]              wgt_wdata;
    logic [8*LANES-1:0]      status_result;
    logic                    status_done;
    logic                    status_busy;

    modport master (
        output ctrl_start, ctrl_num, ctrl_Za, ctrl_Zw, ctrl_Zo, ctrl_M0, ctrl_n,
               ctrl_bias, ctrl_relu, act_we, act_waddr, act_wdata,
               wgt_we, wgt_lane, wgt_waddr, wgt_wdata,
        input  status_result, status_done, status_busy
    );

    modport slave (
        input  ctrl_start, ctrl_num, ctrl_Za, ctrl_Zw, ctrl_Zo, ctrl_M0, ctrl_n,
               ctrl_bias, ctrl_relu, act_we, act_waddr, act_wdata,
               wgt_we, wgt_lane, wgt_waddr, wgt_wdata,
        output status_result, status_done, status_busy
    );
endinterface

// File: rtl/mac_vec_ip.sv
// Quantized int8 vector MAC. One shared activation vector is multiplied against LANES weight banks.
// Each lane then goes through bias addition, fixed-point requantization, saturation and optional ReLU.
module mac_vec_ip #(
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int MO_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       rstn,
    mac_vec_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = 32 + MO_WIDTH;

    localparam logic [ADDR_WIDTH:0] NUM_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] NUM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW:0]         SAT_HI   = {{(PW-6){1'b0}}, 7'h7f};
    localparam logic [PW:0]         SAT_LO   = {{(PW-6){1'b1}}, 7'h00};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        REQ1  = 3'd3,
        REQ2  = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic start_acc_s;
    logic run_en_s;
    logic p_load_s;
    logic res_load_s;

    logic [7:0]            act_mem [DEPTH];
    logic [7:0]            wgt_mem [LANES][DEPTH];
    logic [7:0]            act_rd_r;
    logic [7:0]            wgt_rd_r [LANES];

    logic [ADDR_WIDTH:0]   rd_addr_r;
    logic                  rd_valid_r;
    logic [ADDR_WIDTH:0]   num_r;
    logic [7:0]            za_r;
    logic [7:0]            zw_r;
    logic [7:0]            zo_r;
    logic [MO_WIDTH-1:0]   m0_r;
    logic [5:0]            n_r;
    logic [31:0]           bias_r [LANES];
    logic                  relu_r;
    logic [31:0]           acc_r [LANES];
    logic [PW-1:0]         p_r [LANES];
    logic [8*LANES-1:0]    result_r;
    logic                  busy_r;
    logic                  done_r;

    logic [8:0]            da_s;
    logic [8:0]            dw_s [LANES];
    logic [17:0]           term_s [LANES];
    logic [31:0]           sum_s [LANES];
    logic [PW-1:0]         prod_s [LANES];
    logic [PW:0]           rnd_s;
    logic [PW:0]           shr_s [LANES];
    logic [PW:0]           zsum_s [LANES];
    logic [7:0]            sat_s [LANES];
    logic [7:0]            res_s [LANES];

    // Activation BRAM: registered read, so a same-address write returns the old data
    always_ff @(posedge clk) begin
        if (bus.act_we) begin
            act_mem[bus.act_waddr] <= bus.act_wdata;
        end
        if (run_en_s) begin
            act_rd_r <= act_mem[rd_addr_r[ADDR_WIDTH-1:0]];
        end
    end

    // Weight BRAM banks, one per lane, all sharing the activation read address
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (bus.wgt_we && (bus.wgt_lane == LW'(i))) begin
                wgt_mem[i][bus.wgt_waddr] <= bus.wgt_wdata;
            end
            if (run_en_s) begin
                wgt_rd_r[i] <= wgt_mem[i][rd_addr_r[ADDR_WIDTH-1:0]];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ctrl_start) begin
                    state_nxt_s = (bus.ctrl_num == NUM_ZERO) ? REQ1 : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (rd_addr_r == (num_r - NUM_ONE)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN:   state_nxt_s = REQ1;
            REQ1:    state_nxt_s = REQ2;
            REQ2:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        start_acc_s = 1'b0;
        run_en_s    = 1'b0;
        p_load_s    = 1'b0;
        res_load_s  = 1'b0;
        case (state_r)
            IDLE:    start_acc_s = bus.ctrl_start;
            RUN:     run_en_s    = 1'b1;
            DRAIN:   run_en_s    = 1'b0;
            REQ1:    p_load_s    = 1'b1;
            REQ2:    res_load_s  = 1'b1;
            default: run_en_s    = 1'b0;
        endcase
    end

    // Per-lane arithmetic. Operands are sign-extended to full width first,
    // so the truncated unsigned products are exact two's-complement results.
    always_comb begin
        da_s  = {act_rd_r[7], act_rd_r} - {za_r[7], za_r};
        rnd_s = {(PW+1){1'b0}};
        if (n_r != 6'd0) begin
            rnd_s = {{PW{1'b0}}, 1'b1} << (n_r - 6'd1);
        end else begin
            rnd_s = {(PW+1){1'b0}};
        end
        for (int i = 0; i < LANES; i++) begin
            dw_s[i]   = {wgt_rd_r[i][7], wgt_rd_r[i]} - {zw_r[7], zw_r};
            term_s[i] = {{9{da_s[8]}}, da_s} * {{9{dw_s[i][8]}}, dw_s[i]};
            sum_s[i]  = acc_r[i] + bias_r[i];
            prod_s[i] = {{MO_WIDTH{sum_s[i][31]}}, sum_s[i]} * {{32{m0_r[MO_WIDTH-1]}}, m0_r};
            shr_s[i]  = $signed({p_r[i][PW-1], p_r[i]} + rnd_s) >>> n_r;
            zsum_s[i] = shr_s[i] + {{(PW-7){zo_r[7]}}, zo_r};
            if ($signed(zsum_s[i]) > $signed(SAT_HI)) begin
                sat_s[i] = 8'h7f;
            end else if ($signed(zsum_s[i]) < $signed(SAT_LO)) begin
                sat_s[i] = 8'h80;
            end else begin
                sat_s[i] = zsum_s[i][7:0];
            end
            if (relu_r && ($signed(sat_s[i]) < $signed(zo_r))) begin
                res_s[i] = zo_r;
            end else begin
                res_s[i] = sat_s[i];
            end
        end
    end

    // Run configuration, read address, accumulators, pipeline and status registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_r  <= NUM_ZERO;
            rd_valid_r <= 1'b0;
            num_r      <= NUM_ZERO;
            za_r       <= 8'h00;
            zw_r       <= 8'h00;
            zo_r       <= 8'h00;
            m0_r       <= {MO_WIDTH{1'b0}};
            n_r        <= 6'd0;
            relu_r     <= 1'b0;
            result_r   <= {(8*LANES){1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                bias_r[i] <= 32'h0;
                acc_r[i]  <= 32'h0;
                p_r[i]    <= {PW{1'b0}};
            end
        end else begin
            rd_valid_r <= run_en_s;
            if (start_acc_s) begin
                rd_addr_r <= NUM_ZERO;
                num_r     <= bus.ctrl_num;
                za_r      <= bus.ctrl_Za;
                zw_r      <= bus.ctrl_Zw;
                zo_r      <= bus.ctrl_Zo;
                m0_r      <= bus.ctrl_M0;
                n_r       <= bus.ctrl_n;
                relu_r    <= bus.ctrl_relu;
                busy_r    <= 1'b1;
                done_r    <= 1'b0;
                for (int i = 0; i < LANES; i++) begin
                    bias_r[i] <= bus.ctrl_bias[32*i +: 32];
                    acc_r[i]  <= 32'h0;
                end
            end else begin
                if (run_en_s) begin
                    rd_addr_r <= rd_addr_r + NUM_ONE;
                end
                for (int i = 0; i < LANES; i++) begin
                    if (rd_valid_r) begin
                        acc_r[i] <= acc_r[i] + {{14{term_s[i][17]}}, term_s[i]};
                    end
                    if (p_load_s) begin
                        p_r[i] <= prod_s[i];
                    end
                    if (res_load_s) begin
                        result_r[8*i +: 8] <= res_s[i];
                    end
                end
                if (res_load_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.status_result = result_r;
    assign bus.status_done   = done_r;
    assign bus.status_busy   = busy_r;

endmodule
